fp_mul_round_stage: RTL and testbench
=====================================

FP_MUL_ROUND_STAGE -- requirements
Module: fp_mul_round_stage

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32: packed result width.
REQ-002 SHALL have parameter E_WIDTH, default 8: exponent field width.
REQ-003 SHALL have parameter M_WIDTH, default 23: stored mantissa width.
REQ-004 SHALL have parameter P_WIDTH, default 48: raw significand product width, equal to 2*(M_WIDTH+1).
REQ-005 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: upstream operand bundle is valid.
REQ-008 SHALL have port in_ready, output, 1: stage accepts the bundle this cycle.
REQ-009 SHALL have port in_sign, input, 1: result sign (sign1 XOR sign2).
REQ-010 SHALL have port in_exp, input, E_WIDTH+2: two's-complement biased exponent exp1+exp2-127.
REQ-011 SHALL have port in_prod, input, P_WIDTH: raw product of {1,m1}*{1,m2}.
REQ-012 SHALL have ports in_nan, in_inf and in_zero, input, 1 each: upstream operand-class flags.
REQ-013 SHALL have port out_valid, output, 1: result is valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-015 SHALL have port out_result, output, D_WIDTH: packed {sign, exponent, mantissa}.
REQ-016 SHALL have ports out_overflow, out_underflow and out_inexact, output, 1 each: exception flags qualified by out_valid.

Function
REQ-017 SHALL transfer on the input side when in_valid & in_ready, and on the output side when out_valid & out_ready.
REQ-018 SHALL be a two-register pipeline: S1 normalizes, S2 rounds and packs; latency is 2 cycles from input transfer to out_valid with no stall.
REQ-019 SHALL advance S2 when out_ready | !s2_valid, advance S1 when !s1_valid | S2-advance, and drive in_ready = S1-advance; full throughput is 1 result per cycle.
REQ-020 SHALL hold out_result and all flags stable while out_valid & !out_ready.
REQ-021 SHALL normalize in S1 as follows:
  - if prod[47]=1: mant=prod[46:24], guard=prod[23], sticky=|prod[22:0], exp=in_exp+1.
  - otherwise: mant=prod[45:23], guard=prod[22], sticky=|prod[21:0], exp=in_exp.
REQ-022 SHALL round to nearest even in S2: increment mant when guard & (sticky | mant[0]); inexact = guard | sticky.
REQ-023 SHALL, on mantissa carry-out (all-ones plus 1), set mant=0 and exp=exp+1.
REQ-024 SHALL produce overflow when the final exp >= 255: result {sign, 0xFF, 0}, out_overflow=1, out_inexact=1.
REQ-025 SHALL produce underflow when the final exp <= 0: flush to {sign, 0x00, 0}, out_underflow=1, out_inexact=1 (no denormal output).
REQ-026 SHALL apply special classes with priority nan > inf > zero, overriding REQ-021..025 with all flags 0:
  - nan: 0x7FC00000.
  - inf: {sign, 0xFF, 0}.
  - zero: {sign, 0x00, 0}.
REQ-027 SHALL accept new input in the same cycle that the held result drains (simultaneous in/out transfer).

Reset
REQ-028 SHALL clear s1_valid, s2_valid and out_valid to 0 on rst, and clear out_result and all flags to 0.
REQ-029 SHALL discard in-flight bundles when rst is asserted mid-operation, and hold in_ready=0 while rst=1.

Structure
REQ-030 SHALL place D_WIDTH/E_WIDTH/M_WIDTH/P_WIDTH defaults, BIAS=127, EXP_MAX=255 and QNAN=0x7FC00000 in the shared FPU package.
REQ-031 SHALL implement rounding (REQ-022/023) as one sub-module, fp_round_rne; normalization and pack remain inline.

Verification
REQ-032 SHALL cover: prod=0x900000000000, in_exp=127, sign=0 -> 0x40100000 (1.5*1.5=2.25), flags 0, at cycle 2.
REQ-033 SHALL cover tie cases: prod bit47=0, guard=1, sticky=0, mant lsb=0 -> no increment, inexact=1; same with lsb=1 -> mant+1.
REQ-034 SHALL cover: prod=0x800000000000, in_exp=254 -> 0x7F800000, overflow=1, inexact=1.
REQ-035 SHALL cover: prod=0x400000000000, in_exp=0 -> 0x00000000, underflow=1.
REQ-036 SHALL cover special classes: in_nan=1 and in_inf=1 -> 0x7FC00000; in_zero=1, sign=1 -> 0x80000000.
REQ-037 SHALL cover backpressure: stream 3 bundles with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts, out_result stable, all 3 results in order; rst pulse mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/fp_mul_round_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : fp_mul_round_stage_pkg
// Brief    : Shared FPU constants and operand-class helper for the multiplier.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fp_mul_round_stage_pkg;

    localparam int FP_D_WIDTH = 32;
    localparam int FP_E_WIDTH = 8;
    localparam int FP_M_WIDTH = 23;
    localparam int FP_P_WIDTH = 48;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    // NaN dominates infinity, which dominates zero.
    function automatic fp_class_e fp_classify(input logic nan, input logic inf, input logic zero);
        fp_class_e cls;
        cls = CLS_NORM;
        if (nan)       cls = CLS_NAN;
        else if (inf)  cls = CLS_INF;
        else if (zero) cls = CLS_ZERO;
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mul_round_stage_round.sv
//------------------------------------------------------------------------------
// Module   : fp_round_rne
// Brief    : Round-to-nearest-even of a normalized mantissa with carry into exp.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp_round_rne
    import fp_mul_round_stage_pkg::*;
#(
    parameter int E_WIDTH = FP_E_WIDTH,
    parameter int M_WIDTH = FP_M_WIDTH
) (
    input  logic [M_WIDTH-1:0] mant_in,
    input  logic               guard,
    input  logic               sticky,
    input  logic [E_WIDTH+1:0] exp_in,
    output logic [M_WIDTH-1:0] mant_out,
    output logic [E_WIDTH+1:0] exp_out,
    output logic               inexact
);

    logic             w_round_up;
    logic [M_WIDTH:0] w_sum;

    assign w_round_up = guard & (sticky | mant_in[0]);
    // An all-ones mantissa wraps to zero and the carry bumps the exponent.
    assign w_sum      = {1'b0, mant_in} + {{M_WIDTH{1'b0}}, w_round_up};
    assign mant_out   = w_sum[M_WIDTH-1:0];
    assign exp_out    = exp_in + {{(E_WIDTH+1){1'b0}}, w_sum[M_WIDTH]};
    assign inexact    = guard | sticky;

endmodule

`default_nettype wire

// File: rtl/fp_mul_round_stage.sv
//------------------------------------------------------------------------------
// Module   : fp_mul_round_stage
// Brief    : Two-stage FP multiply back end: S1 normalizes, S2 rounds and packs.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp_mul_round_stage
    import fp_mul_round_stage_pkg::*;
#(
    parameter int D_WIDTH = FP_D_WIDTH,
    parameter int E_WIDTH = FP_E_WIDTH,
    parameter int M_WIDTH = FP_M_WIDTH,
    parameter int P_WIDTH = FP_P_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [E_WIDTH+1:0] in_exp,
    input  logic [P_WIDTH-1:0] in_prod,
    input  logic               in_nan,
    input  logic               in_inf,
    input  logic               in_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_result,
    output logic               out_overflow,
    output logic               out_underflow,
    output logic               out_inexact
);

    localparam int c_hi_msb  = P_WIDTH - 2;
    localparam int c_hi_grd  = P_WIDTH - 2 - M_WIDTH;
    localparam int c_lo_msb  = P_WIDTH - 3;
    localparam int c_lo_grd  = P_WIDTH - 3 - M_WIDTH;
    localparam int c_exp_max = (1 << E_WIDTH) - 1;

    localparam logic [E_WIDTH+1:0] c_exp_max_v = c_exp_max[E_WIDTH+1:0];
    localparam logic [E_WIDTH+1:0] c_exp_one   = {{(E_WIDTH+1){1'b0}}, 1'b1};
    localparam logic [D_WIDTH-1:0] c_qnan      = {1'b0, {E_WIDTH{1'b1}}, 1'b1, {(M_WIDTH-1){1'b0}}};

    // Handshake
    logic w_s2_adv;
    logic w_s1_adv;

    // S1 normalize (combinational inputs to the S1 register)
    logic [M_WIDTH-1:0] w_norm_mant;
    logic               w_norm_guard;
    logic               w_norm_sticky;
    logic [E_WIDTH+1:0] w_norm_exp;

    // S1 register
    logic               r_s1_valid;
    logic               r_s1_sign;
    logic [E_WIDTH+1:0] r_s1_exp;
    logic [M_WIDTH-1:0] r_s1_mant;
    logic               r_s1_guard;
    logic               r_s1_sticky;
    fp_class_e          r_s1_cls;

    // S2 round and pack
    logic [M_WIDTH-1:0] w_rnd_mant;
    logic [E_WIDTH+1:0] w_rnd_exp;
    logic               w_rnd_inexact;
    logic [D_WIDTH-1:0] w_pack_result;
    logic               w_pack_ovf;
    logic               w_pack_unf;
    logic               w_pack_inexact;

    assign w_s2_adv = out_ready | ~out_valid;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv & ~rst;

    always_comb begin
        w_norm_mant   = in_prod[c_lo_msb -: M_WIDTH];
        w_norm_guard  = in_prod[c_lo_grd];
        w_norm_sticky = |in_prod[c_lo_grd-1:0];
        w_norm_exp    = in_exp;
        if (in_prod[P_WIDTH-1]) begin
            w_norm_mant   = in_prod[c_hi_msb -: M_WIDTH];
            w_norm_guard  = in_prod[c_hi_grd];
            w_norm_sticky = |in_prod[c_hi_grd-1:0];
            w_norm_exp    = in_exp + c_exp_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_mant   <= '0;
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
            r_s1_cls    <= CLS_NORM;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign   <= in_sign;
                r_s1_exp    <= w_norm_exp;
                r_s1_mant   <= w_norm_mant;
                r_s1_guard  <= w_norm_guard;
                r_s1_sticky <= w_norm_sticky;
                r_s1_cls    <= fp_classify(in_nan, in_inf, in_zero);
            end
        end
    end

    fp_round_rne #(
        .E_WIDTH (E_WIDTH),
        .M_WIDTH (M_WIDTH)
    ) u_round (
        .mant_in  (r_s1_mant),
        .guard    (r_s1_guard),
        .sticky   (r_s1_sticky),
        .exp_in   (r_s1_exp),
        .mant_out (w_rnd_mant),
        .exp_out  (w_rnd_exp),
        .inexact  (w_rnd_inexact)
    );

    // Exponent is two's complement, so range tests are signed.
    always_comb begin
        w_pack_result  = {r_s1_sign, w_rnd_exp[E_WIDTH-1:0], w_rnd_mant};
        w_pack_ovf     = 1'b0;
        w_pack_unf     = 1'b0;
        w_pack_inexact = w_rnd_inexact;
        if ($signed(w_rnd_exp) >= $signed(c_exp_max_v)) begin
            w_pack_result  = {r_s1_sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
            w_pack_ovf     = 1'b1;
            w_pack_inexact = 1'b1;
        end else if ($signed(w_rnd_exp) <= 0) begin
            w_pack_result  = {r_s1_sign, {E_WIDTH{1'b0}}, {M_WIDTH{1'b0}}};
            w_pack_unf     = 1'b1;
            w_pack_inexact = 1'b1;
        end
        if (r_s1_cls != CLS_NORM) begin
            w_pack_ovf     = 1'b0;
            w_pack_unf     = 1'b0;
            w_pack_inexact = 1'b0;
            case (r_s1_cls)
                CLS_NAN:  w_pack_result = c_qnan;
                CLS_INF:  w_pack_result = {r_s1_sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
                default:  w_pack_result = {r_s1_sign, {E_WIDTH{1'b0}}, {M_WIDTH{1'b0}}};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_result    <= w_pack_result;
                out_overflow  <= w_pack_ovf;
                out_underflow <= w_pack_unf;
                out_inexact   <= w_pack_inexact;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_round_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_fp_mul_round_stage
// Brief    : Directed self-checking bench for the multiplier round stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_mul_round_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_prod;
    logic        in_nan;
    logic        in_inf;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_mul_round_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_prod       (in_prod),
        .in_nan        (in_nan),
        .in_inf        (in_inf),
        .in_zero       (in_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] p,
                         input logic nan, input logic inf, input logic zero);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_prod  = p;
        in_nan   = nan;
        in_inf   = inf;
        in_zero  = zero;
    endtask

    // One isolated bundle; result expected exactly two edges after acceptance.
    task automatic run_vec(input string tag, input logic s, input logic [9:0] e,
                           input logic [47:0] p, input logic nan, input logic inf,
                           input logic zero, input logic [31:0] exp_res,
                           input logic [2:0] exp_flags);
        @(negedge clk);
        out_ready = 1'b1;
        drive(s, e, p, nan, inf, zero);
        #1 check_eq({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, ".lat1_valid"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, ".result"}, out_result, exp_res);
        check_eq({tag, ".flags"}, {29'd0, out_overflow, out_underflow, out_inexact},
                 {29'd0, exp_flags});
    endtask

    logic [47:0] s_prod [3];
    logic [31:0] s_exp  [3];

    initial begin
        int in_idx;
        int out_idx;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 1'b0; in_exp = '0; in_prod = '0;
        in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst.in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst.out_result", out_result, 32'd0);
        check_eq("rst.flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
        rst = 1'b0;

        // flags are {overflow, underflow, inexact}
        run_vec("mul_1p5",    1'b0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 32'h4010_0000, 3'b000);
        run_vec("tie_even",   1'b0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, 32'h3F80_0000, 3'b001);
        run_vec("tie_odd",    1'b0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, 32'h3F80_0002, 3'b001);
        run_vec("sticky_up",  1'b0, 10'd127, 48'h4000_0040_0001, 0, 0, 0, 32'h3F80_0001, 3'b001);
        run_vec("sticky_dn",  1'b1, 10'd127, 48'h4000_0000_0001, 0, 0, 0, 32'hBF80_0000, 3'b001);
        run_vec("carry_out",  1'b0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0, 32'h4000_0000, 3'b001);
        run_vec("max_norm",   1'b0, 10'd254, 48'h4000_0000_0000, 0, 0, 0, 32'h7F00_0000, 3'b000);
        run_vec("ovf",        1'b0, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 32'h7F80_0000, 3'b101);
        run_vec("ovf_carry",  1'b1, 10'd254, 48'h7FFF_FFC0_0000, 0, 0, 0, 32'hFF80_0000, 3'b101);
        run_vec("min_norm",   1'b0, 10'd1,   48'h4000_0000_0000, 0, 0, 0, 32'h0080_0000, 3'b000);
        run_vec("unf",        1'b0, 10'd0,   48'h4000_0000_0000, 0, 0, 0, 32'h0000_0000, 3'b011);
        run_vec("unf_neg",    1'b1, 10'h3FB, 48'h8000_0000_0000, 0, 0, 0, 32'h8000_0000, 3'b011);
        run_vec("nan_inf",    1'b1, 10'd300, 48'h8000_0000_0000, 1, 1, 0, 32'h7FC0_0000, 3'b000);
        run_vec("inf_zero",   1'b1, 10'd0,   48'h0000_0000_0000, 0, 1, 1, 32'hFF80_0000, 3'b000);
        run_vec("zero",       1'b1, 10'd127, 48'h9000_0000_0000, 0, 0, 1, 32'h8000_0000, 3'b000);

        // Backpressure: three bundles, out_ready low through the first six cycles.
        @(negedge clk);
        in_valid = 1'b0;
        s_prod[0] = 48'h9000_0000_0000; s_exp[0] = 32'h4010_0000;
        s_prod[1] = 48'h4000_0000_0000; s_exp[1] = 32'h3F80_0000;
        s_prod[2] = 48'h8000_0000_0000; s_exp[2] = 32'h4000_0000;
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 0; cyc < 30 && out_idx < 3; cyc++) begin
            out_ready = (cyc >= 6);
            if (in_idx < 3) drive(1'b0, 10'd127, s_prod[in_idx], 0, 0, 0);
            else            in_valid = 1'b0;
            #1;
            if (cyc >= 2 && cyc <= 5) begin
                check_eq("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
                check_eq("bp.accepts", in_idx, 32'd2);
                check_eq("bp.held_result", out_result, s_exp[0]);
                check_eq("bp.held_valid", {31'd0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                check_eq("bp.order", out_result, s_exp[out_idx]);
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("bp.drained", out_idx, 32'd3);

        // Reset mid-flight discards both stages.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b0, 10'd127, 48'h9000_0000_0000, 0, 0, 0);
        @(negedge clk);
        drive(1'b0, 10'd127, 48'h4000_0000_0000, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("mid.valid_before", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1 check_eq("mid.in_ready_rst", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check_eq("mid.valid_after", {31'd0, out_valid}, 32'd0);
        check_eq("mid.result_after", out_result, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mid.no_ghost", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
